// File: rtl/spi_ram_ctrl.sv
// Command decoder and MEM_DEPTH x 8 register file behind the SPI slave; RD_DATA -> tx_valid two cycles later.
// Optional SPI_RAM_AUTO_INC_EN: post-increment wr_addr/rd_addr on each accepted WR_DATA/RD_DATA.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [9:0] rx_data,
    input  logic       tx_done,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_FETCH = 2'd1,
        RESP     = 2'd2
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    state_t                state_q, state_d, state_post;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                  wa_ok_q, wa_ok_d;
    logic                  ra_ok_q, ra_ok_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  mem_we;
    logic [7:0]            mem [MEM_DEPTH];

    logic [1:0]            cmd;
    logic [7:0]            payload;
    logic [ADDR_WIDTH-1:0] addr;

    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign addr    = payload[ADDR_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        fetch_addr_d = fetch_addr_q;
        wa_ok_d      = wa_ok_q;
        ra_ok_d      = ra_ok_q;
        tx_data_d    = tx_data_q;
        cmd_err_d    = 1'b0;
        mem_we       = 1'b0;

        // A tx_done in RESP retires the response before this cycle's frame is decoded.
        state_post = state_q;
        if (state_q == RESP && tx_done) begin
            state_post = IDLE;
        end

        case (state_q)
            RD_FETCH: begin
                tx_data_d = mem[fetch_addr_q];
                state_d   = RESP;
            end
            RESP:     state_d = state_post;
            default:  state_d = IDLE;
        endcase

        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = addr;
                    wa_ok_d   = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wa_ok_q) begin
                        mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
`endif
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = addr;
                    ra_ok_d   = 1'b1;
                end
                default: begin
                    if (ra_ok_q && state_post == IDLE) begin
                        state_d      = RD_FETCH;
                        fetch_addr_d = rd_addr_q;
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
`endif
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            fetch_addr_q <= '0;
            wa_ok_q      <= 1'b0;
            ra_ok_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            fetch_addr_q <= fetch_addr_d;
            wa_ok_q      <= wa_ok_d;
            ra_ok_q      <= ra_ok_d;
            tx_data_q    <= tx_data_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_addr_q] <= payload;
        end
    end

    assign tx_valid = (state_q == RESP);
    assign busy     = (state_q == RESP);
    assign tx_data  = tx_data_q;
    assign cmd_err  = cmd_err_q;

endmodule
